// File: rtl/keypad_if.sv
// keypad_if: keypad column drive, row readback and debounced key-event signals.
interface keypad_if;
  logic [3:0] scanData;
  logic [2:0] columnSel;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       keyPressed;
  modport master (input scanData, output columnSel, keyValid, keyCode, keyPressed);
  modport slave (output scanData, input columnSel, keyValid, keyCode, keyPressed);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x4 keypad column scanner with frame-based debounce, ghost rejection and one pulse per press.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input logic clk,
  input logic rst,
  keypad_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DF = CW'(DEBOUNCE_FRAMES);
  // snapshot bit 4*col+row -> key code
  localparam logic [47:0] MAP = {4'hB, 4'h9, 4'h6, 4'h3, 4'h0, 4'h8, 4'h5, 4'h2, 4'hA, 4'h7, 4'h4, 4'h1};
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0] col_q, col_d;
  logic [11:0] snap_q, snap_d;
  logic [3:0] cand_q, cand_d, code_q, code_d, key;
  logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic valid_q, valid_d, pressed_q, pressed_d, last, frame_end, single;
  always_comb begin
    last = dwell_q == DLAST;
    frame_end = last && col_q[2];
    dwell_d = last ? '0 : dwell_q + 1'b1;
    col_d = last ? {col_q[1:0], col_q[2]} : col_q;
    snap_d = snap_q;
    for (int i = 0; i < 3; i++) if (last && col_q[i]) snap_d[4*i +: 4] = kp.scanData;
    single = $countones(snap_d) == 1;
    key = 4'h0;
    for (int i = 0; i < 12; i++) if (snap_d[i]) key = MAP[4*i +: 4];
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    rel_d = rel_q;
    code_d = code_q;
    valid_d = 1'b0;
    pressed_d = pressed_q;
    if (frame_end) begin
      case (state_q)
        IDLE: if (single) begin
          cand_d = key;
          cnt_d = CW'(1);
          state_d = DEBOUNCE;
        end
        DEBOUNCE: if (!single) begin
          state_d = IDLE;
          cnt_d = '0;
        end else begin
          cand_d = key;
          cnt_d = key == cand_q ? cnt_q + 1'b1 : CW'(1);
        end
        HELD: begin
          rel_d = |snap_d ? '0 : rel_q + 1'b1;
          if (rel_d == DF) begin
            state_d = IDLE;
            pressed_d = 1'b0;
            rel_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
      // covers both the normal count-up and the immediate accept when one frame suffices
      if (state_d == DEBOUNCE && cnt_d == DF) begin
        state_d = HELD;
        code_d = cand_d;
        valid_d = 1'b1;
        pressed_d = 1'b1;
        cnt_d = '0;
        rel_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dwell_q <= '0;
      col_q <= 3'b001;
      snap_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
      rel_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      col_q <= col_d;
      snap_q <= snap_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      rel_q <= rel_d;
      code_q <= code_d;
      valid_q <= valid_d;
      pressed_q <= pressed_d;
    end
  end
  assign kp.columnSel = col_q;
  assign kp.keyValid = valid_q;
  assign kp.keyCode = code_q;
  assign kp.keyPressed = pressed_q;
endmodule
